// File: rtl/regfile_pkg.sv
// Shared opcode constants and operand classification
// for the N-port register file read stage.
package regfile_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_HMUL = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_CMP  = 4'hA;
    localparam logic [3:0] OP_LD   = 4'hB;
    localparam logic [3:0] OP_SHL  = 4'hC;
    localparam logic [3:0] OP_SHR  = 4'hD;
    localparam logic [3:0] OP_ROL  = 4'hE;
    localparam logic [3:0] OP_BSR  = 4'hF;

    typedef enum logic [1:0] {
        FULL  = 2'd0,
        HALF  = 2'd1,
        ZERO  = 2'd2,
        SHAMT = 2'd3
    } op_class_e;

    // second=0 selects the src1 class, second=1 the src2 class
    function automatic op_class_e op_class(
        input logic       valid,
        input logic [3:0] op,
        input logic       second
    );
        op_class_e c;
        c = ZERO;
        if (valid) begin
            unique case (op)
                OP_NOP, OP_LDI:                 c = ZERO;
                OP_HMUL:                        c = HALF;
                OP_MOV, OP_NOT, OP_LD:          c = second ? ZERO : FULL;
                OP_SHL, OP_SHR, OP_ROL, OP_BSR: c = second ? SHAMT : FULL;
                default:                        c = FULL;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_opmask.sv
// Combinational operand mask: keeps all, the low half,
// the low shift-amount bits, or none of the operand.
module regfile_opmask
    import regfile_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [1:0]    cls,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    localparam int HW = DW / 2;
    localparam int SW = $clog2(DW);

    // select the surviving bit range for this operand class
    always_comb begin
        dout = '0;
        unique case (cls)
            FULL:    dout = din;
            HALF:    dout[HW-1:0] = din[HW-1:0];
            SHAMT:   dout[SW-1:0] = din[SW-1:0];
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/regfile_nport.sv
// Multi-lane register file with same-cycle write bypass
// and a registered, opcode-masked operand stage.
module regfile_nport
    import regfile_pkg::*;
#(
    parameter int LANES   = 3,
    parameter int DW      = 64,
    parameter int NREG    = 16,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                stall,
    input  logic [LANES-1:0]    f2r_valid,
    input  logic [4*LANES-1:0]  f2r_inst,
    input  logic [AW*LANES-1:0] f2r_src1,
    input  logic [AW*LANES-1:0] f2r_src2,
    input  logic [LANES-1:0]    w2r_wr,
    input  logic [AW*LANES-1:0] w2r_dest,
    input  logic [DW*LANES-1:0] w2r_data,
    output logic [LANES-1:0]    r2e_valid,
    output logic [4*LANES-1:0]  r2e_inst,
    output logic [AW*LANES-1:0] r2e_src1,
    output logic [AW*LANES-1:0] r2e_src2,
    output logic [DW*LANES-1:0] r2e_src1data,
    output logic [DW*LANES-1:0] r2e_src2data
);

    localparam int NP = 2 * LANES;

    logic [DW-1:0] regs [NREG];

    logic [LANES-1:0] wr_en;
    logic [AW-1:0]    rd_idx [NP];
    op_class_e        rd_cls [NP];
    logic [DW-1:0]    rd_raw [NP];
    logic [DW-1:0]    rd_mask [NP];

    // index exists and is not the hard-wired zero register
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return (int'(idx) < NREG) && !(ZERO_R0 != 0 && idx == '0);
    endfunction

    // qualify each lane's write against the index range
    always_comb begin
        for (int w = 0; w < LANES; w++) begin
            wr_en[w] = w2r_wr[w] && idx_ok(w2r_dest[w*AW +: AW]);
        end
    end

    // while stalled, re-read the held indices with the held opcode
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (stall) begin
                rd_idx[2*l]   = r2e_src1[l*AW +: AW];
                rd_idx[2*l+1] = r2e_src2[l*AW +: AW];
                rd_cls[2*l]   = op_class(r2e_valid[l], r2e_inst[l*4 +: 4], 1'b0);
                rd_cls[2*l+1] = op_class(r2e_valid[l], r2e_inst[l*4 +: 4], 1'b1);
            end else begin
                rd_idx[2*l]   = f2r_src1[l*AW +: AW];
                rd_idx[2*l+1] = f2r_src2[l*AW +: AW];
                rd_cls[2*l]   = op_class(f2r_valid[l], f2r_inst[l*4 +: 4], 1'b0);
                rd_cls[2*l+1] = op_class(f2r_valid[l], f2r_inst[l*4 +: 4], 1'b1);
            end
        end
    end

    // array read with bypass; later lanes override earlier ones
    always_comb begin
        for (int k = 0; k < NP; k++) begin
            rd_raw[k] = '0;
            if (idx_ok(rd_idx[k])) begin
                rd_raw[k] = regs[rd_idx[k]];
            end
            for (int w = 0; w < LANES; w++) begin
                if (wr_en[w] && w2r_dest[w*AW +: AW] == rd_idx[k]) begin
                    rd_raw[k] = w2r_data[w*DW +: DW];
                end
            end
        end
    end

    for (genvar k = 0; k < NP; k++) begin : g_mask
        regfile_opmask #(
            .DW(DW)
        ) u_mask (
            .cls (rd_cls[k]),
            .din (rd_raw[k]),
            .dout(rd_mask[k])
        );
    end

    // register array update; last matching lane wins
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < LANES; w++) begin
                if (wr_en[w]) begin
                    regs[w2r_dest[w*AW +: AW]] <= w2r_data[w*DW +: DW];
                end
            end
        end
    end

    // decode-to-execute stage: flush clears, stall holds control
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r2e_valid    <= '0;
            r2e_inst     <= '0;
            r2e_src1     <= '0;
            r2e_src2     <= '0;
            r2e_src1data <= '0;
            r2e_src2data <= '0;
        end else begin
            if (!stall) begin
                r2e_valid <= f2r_valid;
                r2e_inst  <= f2r_inst;
                r2e_src1  <= f2r_src1;
                r2e_src2  <= f2r_src2;
            end
            for (int l = 0; l < LANES; l++) begin
                r2e_src1data[l*DW +: DW] <= rd_mask[2*l];
                r2e_src2data[l*DW +: DW] <= rd_mask[2*l+1];
            end
        end
    end

endmodule

// File: doc/regfile_nport.md
REGFILE_NPORT -- requirements
Module: regfile_nport

Interface
REQ-001 Parameter LANES, default 3, SHALL set the number of issue lanes; each lane has 2 read ports and 1 write port.
REQ-002 Parameter DW, default 64, SHALL set the register data width (even, >=8).
REQ-003 Parameter NREG, default 16, SHALL set the register count; AW = clog2(NREG).
REQ-004 Parameter ZERO_R0, default 0, SHALL make register 0 read as zero and ignore writes to it when 1.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Port clock  in  1  rising-edge clock.
REQ-007 Port reset  in  1  synchronous active-high reset.
REQ-008 Port flush  in  1  kill decode stage; zero all r2e outputs next edge.
REQ-009 Port stall  in  1  hold r2e stage.
REQ-010 Port f2r_valid  in  LANES  lane carries an instruction.
REQ-011 Port f2r_inst  in  4*LANES  per-lane opcode.
REQ-012 Port f2r_src1 / f2r_src2  in  AW*LANES each  per-lane source indices.
REQ-013 Port w2r_wr  in  LANES  per-lane write enable.
REQ-014 Port w2r_dest  in  AW*LANES  per-lane write index.
REQ-015 Port w2r_data  in  DW*LANES  per-lane write data.
REQ-016 Port r2e_valid  out  LANES  registered lane valid.
REQ-017 Port r2e_inst  out  4*LANES  registered opcode.
REQ-018 Port r2e_src1 / r2e_src2  out  AW*LANES each  registered source indices.
REQ-019 Port r2e_src1data / r2e_src2data  out  DW*LANES each  registered masked operands.

Function
REQ-020 Read-to-output latency SHALL be exactly 1 clock; all outputs registered.
REQ-021 Operand masking by opcode SHALL be: 0000/0100/invalid lane -> both 0; 0001,0010,0111,1000,1001,1010 -> both full; 0011 -> both low DW/2 bits, upper bits 0; 0101,0110,1011 -> src1 full, src2 0; 1100-1111 -> src1 full, src2 low clog2(DW) bits only.
REQ-022 Same-cycle write-to-read bypass: a read whose index matches an enabled write in that cycle SHALL return the write data (pre-mask), not the stale register.
REQ-023 Multiple lanes writing one index in a cycle: highest-numbered lane SHALL win for both register update and bypass.
REQ-024 Writes SHALL commit every non-reset cycle regardless of flush or stall.
REQ-025 stall=1, flush=0: r2e_valid, r2e_inst, r2e_src* indices SHALL hold; held operand data SHALL be refreshed (re-masked per held opcode) for any enabled write matching a held source index, so no stale operand leaves the stage.
REQ-026 flush=1 SHALL take priority over stall: all r2e outputs 0 next edge.
REQ-027 stall deasserting SHALL capture new f2r inputs on that same edge (no bubble).
REQ-028 ZERO_R0=1: index 0 reads 0 (bypass included); writes to 0 discarded.
REQ-029 Indices >= NREG (non-power-of-2 NREG) SHALL read 0 and writes SHALL be ignored.

Reset
REQ-030 reset=1 at a rising edge SHALL clear all registers and every r2e output to 0, overriding flush, stall and writes.
REQ-031 Reset mid-stall SHALL discard held state; first post-reset cycle behaves as unstalled.

Structure
REQ-032 Package regfile_pkg SHALL hold opcode constants (OP_NOP..OP_BSR), the operand-class enum (FULL, HALF, ZERO, SHAMT) and the opcode-to-class function.
REQ-033 Sub-module regfile_opmask (combinational, per operand) SHALL apply the class mask; instantiated 2*LANES times, also used on the stall refresh path.

Verification
REQ-034 Reset then read r0..r15 with opcode 0001 -> all operands 0 one cycle later.
REQ-035 Lane0 write r3=0xDEADBEEF_12345678 while lane1 reads r3 with 0001 -> lane1 src1data=0xDEADBEEF_12345678 next edge.
REQ-036 Lanes 0 and 2 both write r5 (0x11, 0x22) -> subsequent read of r5 = 0x22.
REQ-037 r7=0xFFFF_FFFF_FFFF_FFFF, opcode 0011 -> 0x0000_0000_FFFF_FFFF; opcode 1100 src2=r7 -> 0x3F.
REQ-038 Stall with held read of r4, write r4=0x99 during stall -> held src1data becomes 0x99, indices unchanged; flush+stall together -> all outputs 0.
REQ-039 LANES=4, DW=32, NREG=8, ZERO_R0=1 build: write r0=0x5 -> read r0 = 0; opcode 1101 masks src2 to 5 bits.
